// File: rtl/stream_checker.sv
// stream_checker: in-order scoreboard comparing an actual stream against a FIFO of expected beats.
// Define STREAM_CHECKER_CAPTURE_EN to add first-error capture outputs (first_err_exp/act/idx).
module stream_checker #(
   parameter int DATA_W  = 64,
   parameter int DEPTH   = 64,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clear,
   input  logic [DATA_W-1:0]        exp_data,
   input  logic                     exp_vld,
   input  logic [DATA_W-1:0]        act_data,
   input  logic                     act_vld,
   output logic                     match_pulse,
   output logic                     error_pulse,
   output logic [CNT_W-1:0]         match_cnt,
   output logic [CNT_W-1:0]         error_cnt,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     timeout
`ifdef STREAM_CHECKER_CAPTURE_EN
   ,
   output logic [DATA_W-1:0]        first_err_exp,
   output logic [DATA_W-1:0]        first_err_act,
   output logic [CNT_W-1:0]         first_err_idx
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wrPtr;
   logic [AW-1:0]     rdPtr;
   logic [TW-1:0]     toCnt;

   logic isEmpty, isFull, bypass, doPop, doPush, dropBeat, underRun;
   logic beatEq, isMatch, isError;
   logic [DATA_W-1:0] cmpExp;

   always_comb begin
      isEmpty  = (pending == '0);
      isFull   = (pending == FULL_LVL);
      // On an empty FIFO a same-cycle expected beat is compared directly and never stored.
      bypass   = exp_vld & act_vld & isEmpty;
      doPop    = act_vld & ~isEmpty;
      doPush   = exp_vld & ~bypass & (~isFull | doPop);
      dropBeat = exp_vld & isFull & ~act_vld;
      underRun = act_vld & isEmpty & ~exp_vld;
      cmpExp   = bypass ? exp_data : mem[rdPtr];
      beatEq   = (act_data == cmpExp);
      isMatch  = (bypass | doPop) & beatEq;
      isError  = underRun | ((bypass | doPop) & ~beatEq);
   end

   always_ff @(posedge clk) begin
      if (doPush && !clear) mem[wrPtr] <= exp_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         match_pulse <= 1'b0;
         error_pulse <= 1'b0;
         match_cnt   <= '0;
         error_cnt   <= '0;
         pending     <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         timeout     <= 1'b0;
         wrPtr       <= '0;
         rdPtr       <= '0;
         toCnt       <= '0;
      end else if (clear) begin
         match_pulse <= 1'b0;
         error_pulse <= 1'b0;
         match_cnt   <= '0;
         error_cnt   <= '0;
         pending     <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         timeout     <= 1'b0;
         wrPtr       <= '0;
         rdPtr       <= '0;
         toCnt       <= '0;
      end else begin
         match_pulse <= isMatch;
         error_pulse <= isError;
         if (isMatch && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
         if (isError && error_cnt != '1) error_cnt <= error_cnt + 1'b1;
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         if (doPush && !doPop)      pending <= pending + 1'b1;
         else if (doPop && !doPush) pending <= pending - 1'b1;
         if (dropBeat) overflow  <= 1'b1;
         if (underRun) underflow <= 1'b1;
         // Counter holds at TIMEOUT once reached; TIMEOUT of 0 leaves it idle.
         if (isEmpty || act_vld) begin
            toCnt <= '0;
         end else if (TIMEOUT != 0 && toCnt != TO_MAX) begin
            toCnt <= toCnt + 1'b1;
            if (toCnt == TO_MAX - 1'b1) timeout <= 1'b1;
         end
      end
   end

`ifdef STREAM_CHECKER_CAPTURE_EN
   logic             captured;
   logic [CNT_W-1:0] actIdx;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         captured      <= 1'b0;
         actIdx        <= '0;
         first_err_exp <= '0;
         first_err_act <= '0;
         first_err_idx <= '0;
      end else if (clear) begin
         captured      <= 1'b0;
         actIdx        <= '0;
         first_err_exp <= '0;
         first_err_act <= '0;
         first_err_idx <= '0;
      end else begin
         if (act_vld && actIdx != '1) actIdx <= actIdx + 1'b1;
         if (isError && !captured) begin
            captured      <= 1'b1;
            first_err_exp <= underRun ? '0 : cmpExp;
            first_err_act <= act_data;
            first_err_idx <= actIdx;
         end
      end
   end
`endif

endmodule
